// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO draining one store per free memory cycle (first write two edges after accept),
// ST_ready drops when full; combinational load hazard check, optional forwarding under STORE_BUFFER_FORWARD_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        ST_valid,
  output logic        ST_ready,
  input  logic [31:0] ST_address,
  input  logic [31:0] ST_data,
  input  logic [1:0]  ST_length,
  input  logic [31:0] LD_address,
  input  logic [1:0]  LD_length,
  output logic        LD_hazard,
  output logic        LD_fwd_valid,
  output logic [31:0] LD_fwd_data,
  input  logic        MEM_busy,
  output logic [1:0]  MEM_write_length,
  output logic [31:0] MEM_write_address,
  output logic [31:0] MEM_write_data,
  output logic        SB_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   r_q_addr [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [1:0]    r_q_len  [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_wr_len;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_push;
  logic          w_pop;
  logic          w_any_hit;
  logic [PW-1:0] w_idx;

  // Byte sets are [addr, addr+N-1] modulo 2^32; they intersect iff either start lies inside the other set.
  function automatic logic f_overlap(input logic [31:0] a1, input logic [1:0] l1,
                                     input logic [31:0] a2, input logic [1:0] l2);
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] d12;
    logic [31:0] d21;
    n1  = (l1 == 2'b11) ? 32'd4 : {30'd0, l1};
    n2  = (l2 == 2'b11) ? 32'd4 : {30'd0, l2};
    d12 = a1 - a2;
    d21 = a2 - a1;
    return (l1 != 2'b00) && (l2 != 2'b00) && ((d12 < n2) || (d21 < n1));
  endfunction

  assign ST_ready = (r_count < CW'(DEPTH));
  assign w_push   = ST_valid && ST_ready && (ST_length != 2'b00);
  assign w_pop    = !MEM_busy && (r_count != '0);

  always_ff @(posedge SYS_clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= ST_address;
      r_q_data[r_wr_ptr] <= ST_data;
      r_q_len[r_wr_ptr]  <= ST_length;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wr_len  <= 2'b00;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_wr_len  <= r_q_len[r_rd_ptr];
        r_wr_addr <= r_q_addr[r_rd_ptr];
        r_wr_data <= r_q_data[r_rd_ptr];
      end else begin
        r_wr_len  <= 2'b00;
      end
    end
  end

  assign MEM_write_length  = r_wr_len;
  assign MEM_write_address = r_wr_addr;
  assign MEM_write_data    = r_wr_data;
  assign SB_empty          = (r_count == '0) && (r_wr_len == 2'b00);

`ifdef STORE_BUFFER_FORWARD_EN
  logic [31:0] w_young_addr;
  logic [31:0] w_young_data;
  logic [1:0]  w_young_len;
  logic        w_match;

  function automatic logic [31:0] f_mask(input logic [1:0] len);
    case (len)
      2'b01:   return 32'h0000_00FF;
      2'b10:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction
`endif

  // Walk oldest (in-flight write) to youngest queued entry so the last hit is the youngest overlap.
  always_comb begin
    w_any_hit = f_overlap(r_wr_addr, r_wr_len, LD_address, LD_length);
    w_idx     = r_rd_ptr;
`ifdef STORE_BUFFER_FORWARD_EN
    w_young_addr = r_wr_addr;
    w_young_data = r_wr_data;
    w_young_len  = r_wr_len;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) &&
          f_overlap(r_q_addr[w_idx], r_q_len[w_idx], LD_address, LD_length)) begin
        w_any_hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
        w_young_addr = r_q_addr[w_idx];
        w_young_data = r_q_data[w_idx];
        w_young_len  = r_q_len[w_idx];
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  assign w_match      = w_any_hit && (w_young_addr == LD_address) && (w_young_len == LD_length);
  assign LD_fwd_valid = w_match;
  assign LD_fwd_data  = w_match ? (w_young_data & f_mask(w_young_len)) : 32'd0;
  assign LD_hazard    = w_any_hit && !w_match;
`else
  assign LD_fwd_valid = 1'b0;
  assign LD_fwd_data  = 32'd0;
  assign LD_hazard    = w_any_hit;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port SYS_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port SYS_reset  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ST_valid  input  1  the core presents a store.
REQ-005 SHALL have port ST_ready  output  1  the buffer can accept a store.
REQ-006 SHALL have port ST_address  input  32  store byte address.
REQ-007 SHALL have port ST_data  input  32  store data, right-aligned.
REQ-008 SHALL have port ST_length  input  2  store size: 01 byte, 10 half, 11 word, 00 none.
REQ-009 SHALL have port LD_address  input  32  address of the load currently in the core.
REQ-010 SHALL have port LD_length  input  2  load size, same encoding as ST_length; 00 means no load.
REQ-011 SHALL have port LD_hazard  output  1  the load overlaps a pending store, so the core stalls.
REQ-012 SHALL have port LD_fwd_valid  output  1  forwarded data is valid.
REQ-013 SHALL have port LD_fwd_data  output  32  forwarded store data.
REQ-014 SHALL have port MEM_busy  input  1  main memory write port unavailable this cycle.
REQ-015 SHALL have port MEM_write_length  output  2  write size to main memory, 00 = no write.
REQ-016 SHALL have port MEM_write_address  output  32  write address to main memory.
REQ-017 SHALL have port MEM_write_data  output  32  write data to main memory.
REQ-018 SHALL have port SB_empty  output  1  no entries are queued and no write is in flight.

Function
REQ-019 SHALL enqueue {address, data, length} at the FIFO tail on a clock edge where ST_valid=1, ST_ready=1 and ST_length!=00; ST_length=00 is ignored.
REQ-020 SHALL drive ST_ready = (count < DEPTH), independent of a same-cycle drain; there is no pass-through when full.
REQ-021 SHALL, on each edge with MEM_busy=0 and count>0, pop the head entry into the MEM_write_* output registers; otherwise it SHALL load MEM_write_length=00, holding address and data.
REQ-022 SHALL present each store to memory exactly one cycle per entry, in FIFO order, earliest two edges after acceptance.
REQ-023 SHALL support simultaneous enqueue and dequeue in one edge, leaving count unchanged.
REQ-024 SHALL use pointers that wrap modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-025 SHALL compute LD_hazard combinationally: LD_length!=00 and the load byte set intersects the byte set of any queued entry or of the in-flight output register (MEM_write_length!=00).
REQ-026 SHALL compute byte sets as [addr, addr+N-1] modulo 2^32, with N = 1, 2 or 4, so an access at 0xFFFF_FFFE of length 11 covers 0xFFFF_FFFE..0x0000_0001.
REQ-027 SHALL drive SB_empty = (count==0) and (MEM_write_length==00).

Reset
REQ-028 SHALL, while SYS_reset=0, asynchronously clear the pointers and count and drive MEM_write_length=00, MEM_write_address=0, MEM_write_data=0, LD_fwd_valid=0, LD_fwd_data=0, ST_ready=1 and SB_empty=1.
REQ-029 SHALL discard all queued stores and any in-flight write when reset asserts mid-operation; no partial write is issued.

Configuration
REQ-030 SHALL support macro STORE_BUFFER_FORWARD_EN.
REQ-031 SHALL, with the macro defined, forward the data when the youngest overlapping pending store has the same address and length as the load: LD_fwd_valid=1, LD_fwd_data = that store's data zero-extended to its length, and LD_hazard=0.
REQ-032 SHALL, with the macro defined and any other overlap, drive LD_fwd_valid=0 and LD_hazard=1.
REQ-033 SHALL, with the macro undefined, tie LD_fwd_valid=0 and LD_fwd_data=0, with LD_hazard behaving per REQ-025.

Verification
REQ-034 SHALL show: reset, then a word store 0x100/0xDEADBEEF with MEM_busy=0 -> MEM_write_length=11, MEM_write_address=0x100, MEM_write_data=0xDEADBEEF two edges after acceptance, then SB_empty=1.
REQ-035 SHALL show: MEM_busy=1 and 5 stores with DEPTH=4 -> ST_ready=0 after the 4th; after MEM_busy=0, the 5th store is accepted and writes drain in order.
REQ-036 SHALL show: pending half store at 0x202, byte load at 0x203 -> LD_hazard=1; byte load at 0x204 -> LD_hazard=0.
REQ-037 SHALL show: pending word store at 0xFFFF_FFFE, byte load at 0x0000_0001 -> LD_hazard=1.
REQ-038 SHALL show, with STORE_BUFFER_FORWARD_EN defined: byte stores 0x300/0x11 then 0x300/0x22, byte load at 0x300 -> LD_fwd_valid=1, LD_fwd_data=0x22, LD_hazard=0.
REQ-039 SHALL show: SYS_reset pulsed low with 3 entries queued -> MEM_write_length=00 immediately, SB_empty=1, and no write appears after release.
